// File: rtl/capture_ctrl.sv
// Acquisition sequencer for the channel sampler and circular sample RAM:
// divided sample clock, write strobe/address, pre/post-trigger split, completion.
module capture_ctrl #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              abort,
    input  logic [3:0]        decimator,
    input  logic [ADDR_W-1:0] trig_posn,
    input  logic              triggered,
    output logic              smpl_clk,
    output logic              wrt_smpl,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trace_end
);

    localparam int unsigned DEC_W  = 16;
    localparam int unsigned POST_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DEC_W-1:0]    dec_cnt;
    logic [ADDR_W-1:0]   pre_cnt;
    logic [POST_W-1:0]   post_cnt;

    logic [3:0]          d_eff;
    logic [DEC_W-1:0]    dec_mask;
    logic [ADDR_W-1:0]   trig_c;
    logic [POST_W-1:0]   post_tgt;
    logic [ADDR_W-1:0]   pre_cnt_nxt;
    logic [POST_W-1:0]   post_cnt_nxt;
    logic [ADDR_W-1:0]   waddr_inc;
    logic                sampling;
    logic                run_ok;

    // Next-state and datapath helper decode
    always_comb begin
        state_nxt    = state;
        d_eff        = (decimator == 4'd15) ? 4'd14 : decimator;
        dec_mask     = DEC_W'((32'd2 << d_eff) - 32'd1);
        trig_c       = (32'(trig_posn) >= ENTRIES) ? ADDR_W'(ENTRIES - 1) : trig_posn;
        post_tgt     = POST_W'(ENTRIES) - POST_W'(trig_c);
        // Counts include the strobe presented in the current clk
        pre_cnt_nxt  = pre_cnt + ADDR_W'(wrt_smpl);
        post_cnt_nxt = post_cnt + POST_W'(wrt_smpl);
        waddr_inc    = (waddr == ADDR_W'(ENTRIES - 1)) ? '0 : waddr + ADDR_W'(1);
        sampling     = (state == CAPTURE) || (state == ARMED) || (state == POST);
        run_ok       = run && ((state == IDLE) || (state == DONE));

        case (state)
            IDLE:    if (run) state_nxt = CAPTURE;
            CAPTURE: if (pre_cnt_nxt >= trig_c) state_nxt = ARMED;
            ARMED:   if (triggered) state_nxt = POST;
            POST:    if (post_cnt_nxt >= post_tgt) state_nxt = DONE;
            DONE:    if (run) state_nxt = CAPTURE;
            default: state_nxt = IDLE;
        endcase

        if (abort) state_nxt = IDLE;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dec_cnt      <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            smpl_clk     <= 1'b0;
            wrt_smpl     <= 1'b0;
            waddr        <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            trace_end    <= '0;
        end else begin
            state        <= state_nxt;
            smpl_clk     <= dec_cnt[d_eff];
            wrt_smpl     <= sampling && !abort && ((dec_cnt & dec_mask) == DEC_W'(1));
            armed        <= (state_nxt == ARMED);
            capture_done <= (state_nxt == DONE);

            if (run_ok && !abort) begin
                dec_cnt  <= '0;
                waddr    <= '0;
                pre_cnt  <= '0;
                post_cnt <= '0;
            end else begin
                if (sampling) dec_cnt <= dec_cnt + DEC_W'(1);
                if (wrt_smpl) waddr <= waddr_inc;
                if ((state == CAPTURE) && wrt_smpl) pre_cnt <= pre_cnt_nxt;
                if ((state == ARMED) && (state_nxt == POST)) post_cnt <= '0;
                else if ((state == POST) && wrt_smpl) post_cnt <= post_cnt_nxt;
            end

            if ((state == POST) && (state_nxt == DONE)) trace_end <= waddr;
        end
    end

endmodule
